mmio_result_port: RTL and testbench

- Synthesizable memory-mapped result device on the CPU data bus, alongside main RAM.
- Snoops CPU writes. A write to 0x1000 latches an integer result. A write to 0x1002 starts a walk of the null-terminated string at the written address, using a dedicated second read port into the 16-bit RAM.
- Emits one ASCII byte per word on a valid/ready stream, e.g. to a UART transmitter.
- Gives hardware runs the same result semantics the simulation environment gives.

---
 rtl/mmio_result_port.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mmio_result_port.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_result_port.sv
// ---------------------------------------------------------------------------
// mmio_result_port
//
// Memory-mapped result device that snoops CPU writes on the data bus.
//   - A write to INT_ADDR latches a 16-bit integer result (sticky valid).
//   - A write to STR_ADDR starts walking the null-terminated string that
//     begins at the written byte address. The walk uses a dedicated read port
//     into the 16-bit RAM. Each word read yields one ASCII byte (low byte),
//     which is emitted on a valid/ready character stream.
//
// Optional feature macro: STR_FIFO_EN
//   - Undefined (default): a single-character FSM (IDLE/RD/WAIT/EMIT).
//   - Defined: a FIFO_DEPTH-entry character FIFO decouples the read engine
//     from the stream, allowing one character per cycle.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   i_mem_addr    CPU bus byte address (snooped)
//   i_mem_wr      CPU write strobe (snooped)
//   i_mem_wrdata  CPU write data (snooped)
//   o_str_addr    byte address for string read port (RAM uses [15:1])
//   o_str_rd      string read enable; data returns one cycle later
//   i_str_rddata  string read data
//   o_int_valid   sticky: an integer has been written
//   o_int_data    last integer written
//   o_char_valid  character stream valid
//   o_char_data   character byte
//   i_char_ready  downstream accepts character
//   o_busy        string walk in progress
//   o_str_done    one-cycle pulse when the terminator is read
//   o_err         sticky errors: [0] no terminator within MAX_LEN,
//                 [1] trigger while busy
// ---------------------------------------------------------------------------
module mmio_result_port #(
   parameter logic [15:0] INT_ADDR   = 16'h1000,
   parameter logic [15:0] STR_ADDR   = 16'h1002,
   parameter int          MAX_LEN    = 512,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] i_mem_addr,
   input  logic        i_mem_wr,
   input  logic [15:0] i_mem_wrdata,
   output logic [15:0] o_str_addr,
   output logic        o_str_rd,
   input  logic [15:0] i_str_rddata,
   output logic        o_int_valid,
   output logic [15:0] o_int_data,
   output logic        o_char_valid,
   output logic [7:0]  o_char_data,
   input  logic        i_char_ready,
   output logic        o_busy,
   output logic        o_str_done,
   output logic [1:0]  o_err
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic w_intWrite;
   logic w_strTrig;

   assign w_intWrite = i_mem_wr && (i_mem_addr == INT_ADDR);
   assign w_strTrig  = i_mem_wr && (i_mem_addr == STR_ADDR);

   // Integer result register: captured on any write to INT_ADDR regardless
   // of what the string engine is doing; valid stays set until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_int_valid <= 1'b0;
         o_int_data  <= 16'h0000;
      end else if (w_intWrite) begin
         o_int_valid <= 1'b1;
         o_int_data  <= i_mem_wrdata;
      end
   end

`ifndef STR_FIFO_EN

   typedef enum logic [1:0] {IDLE, RD, WAIT, EMIT} stateType;

   stateType         r_state;
   stateType         w_nextState;
   logic [15:0]      r_ptr;
   logic [LEN_W-1:0] r_len;
   logic [7:0]       r_charData;
   logic [1:0]       r_err;
   logic             w_strDone;
   logic             w_wordZero;
   logic             w_lenFull;

   assign w_wordZero = (i_str_rddata == 16'h0000);
   assign w_lenFull  = (r_len == LEN_W'(MAX_LEN));

   // State register for the single-character walk engine.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The terminator is recognised while in WAIT, so the
   // done pulse is asserted in that same cycle; a trigger landing on that
   // edge still sees a non-IDLE state and is treated as a busy trigger.
   always_comb begin
      w_nextState = r_state;
      w_strDone   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_strTrig) w_nextState = RD;
         end
         RD: begin
            w_nextState = WAIT;
         end
         WAIT: begin
            if (w_wordZero) begin
               w_strDone   = 1'b1;
               w_nextState = IDLE;
            end else if (w_lenFull) begin
               w_nextState = IDLE;
            end else begin
               w_nextState = EMIT;
            end
         end
         EMIT: begin
            if (i_char_ready) w_nextState = RD;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Walk datapath: pointer, length and the registered character. The length
   // only increments on a handshake, which cannot happen once it has reached
   // MAX_LEN, so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr      <= 16'h0000;
         r_len      <= '0;
         r_charData <= 8'h00;
         r_err      <= 2'b00;
      end else begin
         if (w_strTrig && (r_state != IDLE)) r_err[1] <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_strTrig) begin
                  r_ptr <= i_mem_wrdata;
                  r_len <= '0;
               end
            end
            WAIT: begin
               if (!w_wordZero) begin
                  if (w_lenFull) r_err[0] <= 1'b1;
                  else           r_charData <= i_str_rddata[7:0];
               end
            end
            EMIT: begin
               if (i_char_ready) begin
                  r_ptr <= r_ptr + 16'd2;
                  r_len <= r_len + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_str_rd     = (r_state == RD);
   assign o_str_addr   = o_str_rd ? r_ptr : 16'h0000;
   assign o_char_valid = (r_state == EMIT);
   assign o_char_data  = r_charData;
   assign o_busy       = (r_state != IDLE);
   assign o_str_done   = w_strDone;
   assign o_err        = r_err;

`else

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]       r_fifo [FIFO_DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             r_issuing;
   logic             r_rdPending;
   logic [15:0]      r_ptr;
   logic [LEN_W-1:0] r_len;
   logic [1:0]       r_err;
   logic             w_term;
   logic             w_lenHit;
   logic             w_enq;
   logic             w_deq;
   logic             w_rdIssue;
   logic             w_busy;

   // Returned data is only ever from the active walk: reads are never issued
   // in the cycle the terminator or the length limit is seen, so nothing past
   // the end of the string is ever in flight.
   assign w_term    = r_rdPending && (i_str_rddata == 16'h0000);
   assign w_lenHit  = r_rdPending && (i_str_rddata != 16'h0000)
                      && (r_len == LEN_W'(MAX_LEN));
   assign w_enq     = r_rdPending && (i_str_rddata != 16'h0000) && !w_lenHit;
   assign w_deq     = (r_count != '0) && i_char_ready;
   assign w_rdIssue = r_issuing && !w_term && !w_lenHit
                      && ((int'(r_count) + int'(r_rdPending)) < FIFO_DEPTH);
   assign w_busy    = r_issuing || r_rdPending || (r_count != '0);

   // Read engine and character FIFO. Occupancy plus reads in flight bounds
   // issue so every returned character is guaranteed a free slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_issuing   <= 1'b0;
         r_rdPending <= 1'b0;
         r_ptr       <= 16'h0000;
         r_len       <= '0;
         r_err       <= 2'b00;
      end else begin
         r_rdPending <= w_rdIssue;
         if (w_strTrig) begin
            if (w_busy) begin
               r_err[1] <= 1'b1;
            end else begin
               r_issuing <= 1'b1;
               r_ptr     <= i_mem_wrdata;
               r_len     <= '0;
            end
         end
         if (w_rdIssue) r_ptr <= r_ptr + 16'd2;
         if (w_term || w_lenHit) r_issuing <= 1'b0;
         if (w_lenHit) r_err[0] <= 1'b1;
         if (w_enq) begin
            r_fifo[r_wrPtr] <= i_str_rddata[7:0];
            r_wrPtr         <= r_wrPtr + 1'b1;
            r_len           <= r_len + 1'b1;
         end
         if (w_deq) r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   assign o_str_rd     = w_rdIssue;
   assign o_str_addr   = w_rdIssue ? r_ptr : 16'h0000;
   assign o_char_valid = (r_count != '0);
   assign o_char_data  = r_fifo[r_rdPtr];
   assign o_busy       = w_busy;
   assign o_str_done   = w_term;
   assign o_err        = r_err;

`endif

endmodule

// File: tb/tb_mmio_result_port.sv
// ---------------------------------------------------------------------------
// tb_mmio_result_port
//
// Self-checking bench for mmio_result_port. A behavioural RAM model answers
// the string read port one cycle after each read. Expected characters are
// queued when a walk is started; a monitor pops and compares them on every
// stream handshake.
// ---------------------------------------------------------------------------
module tb_mmio_result_port;

   localparam logic [15:0] INT_A = 16'h1000;
   localparam logic [15:0] STR_A = 16'h1002;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] memAddr = 16'h0000;
   logic        memWr = 1'b0;
   logic [15:0] memWrdata = 16'h0000;
   logic [15:0] strAddr;
   logic        strRd;
   logic [15:0] strRddata = 16'h0000;
   logic        intValid;
   logic [15:0] intData;
   logic        charValid;
   logic [7:0]  charData;
   logic        charReady = 1'b1;
   logic        busy;
   logic        strDone;
   logic [1:0]  err;

   logic [15:0] ram [0:32767];
   logic [7:0]  expQ [$];
   logic [15:0] rdLog [$];
   int          assertCount = 0;
   int          failCount = 0;
   int          rdCount = 0;
   int          doneCount = 0;
   int          charCount = 0;
   int          cyc = 0;
   int          firstValidCyc = -1;

   mmio_result_port dut (
      .clk          (clk),
      .reset        (reset),
      .i_mem_addr   (memAddr),
      .i_mem_wr     (memWr),
      .i_mem_wrdata (memWrdata),
      .o_str_addr   (strAddr),
      .o_str_rd     (strRd),
      .i_str_rddata (strRddata),
      .o_int_valid  (intValid),
      .o_int_data   (intData),
      .o_char_valid (charValid),
      .o_char_data  (charData),
      .i_char_ready (charReady),
      .o_busy       (busy),
      .o_str_done   (strDone),
      .o_err        (err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      forever #5 clk = ~clk;
   end

   // RAM model with one-cycle read latency; also logs every read address.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (strRd) begin
         strRddata <= ram[strAddr[15:1]];
         rdLog.push_back(strAddr);
         rdCount <= rdCount + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: counts done pulses and compares each accepted character
   // against the head of the expected queue.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (!reset) begin
         if (strDone) doneCount++;
         if (charValid && firstValidCyc < 0) firstValidCyc = cyc;
         if (charValid && charReady) begin
            charCount++;
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedChar: got 0x%0h, expected no character", charData);
            end else begin
               e = expQ.pop_front();
               checkOutput("charData", {24'h0, charData}, {24'h0, e});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One CPU bus write, sampled by the DUT at the next rising edge.
   task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
      memAddr   = addr;
      memWrdata = data;
      memWr     = 1'b1;
      tick();
      memWr     = 1'b0;
      memAddr   = 16'h0000;
      memWrdata = 16'h0000;
   endtask

   task automatic waitIdle(input int budget);
      for (int i = 0; i < budget && busy; i++) tick();
      checkOutput("walkEnds", {31'h0, busy}, 32'h0);
   endtask

   task automatic waitValid(input int budget);
      for (int i = 0; i < budget && !charValid; i++) tick();
      checkOutput("charAppears", {31'h0, charValid}, 32'h1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stimulus
      int doneBefore;
      int charBefore;
      int rdBefore;
      int trigCyc;

      for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
      ram[16'h1000] = 16'h0048;
      ram[16'h1001] = 16'h0069;
      ram[16'h1002] = 16'h0000;
      ram[16'h7FFF] = 16'h0041;
      ram[16'h0000] = 16'h0000;
      ram[16'h1800] = 16'h0100;
      ram[16'h1801] = 16'h0042;
      ram[16'h1802] = 16'h0000;
      for (int i = 0; i < 600; i++) ram[16'h2000 + i] = 16'h0041 + 16'(i % 26);
      ram[16'h2800] = 16'h0058;
      ram[16'h2801] = 16'h0059;
      ram[16'h2802] = 16'h0000;

      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checkOutput("rstIntValid", {31'h0, intValid}, 32'h0);
      checkOutput("rstIntData", {16'h0, intData}, 32'h0);
      checkOutput("rstStrRd", {31'h0, strRd}, 32'h0);
      checkOutput("rstStrAddr", {16'h0, strAddr}, 32'h0);
      checkOutput("rstCharValid", {31'h0, charValid}, 32'h0);
      checkOutput("rstCharData", {24'h0, charData}, 32'h0);
      checkOutput("rstBusy", {31'h0, busy}, 32'h0);
      checkOutput("rstDone", {31'h0, strDone}, 32'h0);
      checkOutput("rstErr", {30'h0, err}, 32'h0);

      // Integer capture, including an ignored write to another address
      applyStimulus(16'h1004, 16'h1234);
      checkOutput("otherAddrIgnored", {31'h0, intValid}, 32'h0);
      applyStimulus(INT_A, 16'hBEEF);
      checkOutput("intValid", {31'h0, intValid}, 32'h1);
      checkOutput("intData", {16'h0, intData}, 32'h0000BEEF);
      checkOutput("intNoBusy", {31'h0, busy}, 32'h0);

      // "Hi" with ready held high
      rdLog.delete();
      firstValidCyc = -1;
      doneBefore = doneCount;
      expQ.push_back(8'h48);
      expQ.push_back(8'h69);
      applyStimulus(STR_A, 16'h2000);
      trigCyc = cyc;
      waitIdle(100);
`ifndef STR_FIFO_EN
      // Counter value after edge N is N; valid is first seen two edges later.
      checkOutput("firstValidLatency", 32'(firstValidCyc - trigCyc), 32'd2);
`endif
      checkOutput("hiDoneOnce", 32'(doneCount - doneBefore), 32'd1);
      checkOutput("hiReadCount", 32'(rdLog.size()), 32'd3);
      if (rdLog.size() == 3) begin
         checkOutput("hiRead0", {16'h0, rdLog[0]}, 32'h2000);
         checkOutput("hiRead1", {16'h0, rdLog[1]}, 32'h2002);
         checkOutput("hiRead2", {16'h0, rdLog[2]}, 32'h2004);
      end
      checkOutput("hiQueueEmpty", 32'(expQ.size()), 32'd0);

      // Backpressure on the first character
      charReady = 1'b0;
      expQ.push_back(8'h48);
      expQ.push_back(8'h69);
      applyStimulus(STR_A, 16'h2000);
      waitValid(20);
      rdBefore = rdCount;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stallValid", {31'h0, charValid}, 32'h1);
         checkOutput("stallData", {24'h0, charData}, 32'h48);
      end
`ifndef STR_FIFO_EN
      checkOutput("stallNoRead", 32'(rdCount - rdBefore), 32'd0);
`endif
      charReady = 1'b1;
      waitIdle(100);
      checkOutput("stallQueueEmpty", 32'(expQ.size()), 32'd0);

      // Pointer wrap from 0xFFFE to 0x0000
      rdLog.delete();
      expQ.push_back(8'h41);
      applyStimulus(STR_A, 16'hFFFE);
      waitIdle(100);
      checkOutput("wrapReadCount", 32'(rdLog.size()), 32'd2);
      if (rdLog.size() == 2) begin
         checkOutput("wrapRead0", {16'h0, rdLog[0]}, 32'hFFFE);
         checkOutput("wrapRead1", {16'h0, rdLog[1]}, 32'h0000);
      end
      checkOutput("wrapQueueEmpty", 32'(expQ.size()), 32'd0);

      // Zero low byte with nonzero high byte emits 0x00 and continues
      expQ.push_back(8'h00);
      expQ.push_back(8'h42);
      applyStimulus(STR_A, 16'h3000);
      waitIdle(100);
      checkOutput("zeroLowQueueEmpty", 32'(expQ.size()), 32'd0);
      checkOutput("errStillClear", {30'h0, err}, 32'h0);

      // Missing terminator: exactly MAX_LEN chars, plus a busy trigger
      charBefore = charCount;
      for (int i = 0; i < 512; i++) expQ.push_back(8'h41 + 8'(i % 26));
      applyStimulus(STR_A, 16'h4000);
      repeat (100) tick();
      applyStimulus(STR_A, 16'h2000);
      checkOutput("busyTrigErr", {31'h0, err[1]}, 32'h1);
      waitIdle(4000);
      checkOutput("maxLenChars", 32'(charCount - charBefore), 32'd512);
      checkOutput("maxLenErr", {30'h0, err}, 32'h3);
      checkOutput("maxLenQueueEmpty", 32'(expQ.size()), 32'd0);

      // Asynchronous reset while a character is waiting for ready
      charReady = 1'b0;
      applyStimulus(STR_A, 16'h5000);
      waitValid(20);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncRstValid", {31'h0, charValid}, 32'h0);
      checkOutput("asyncRstBusy", {31'h0, busy}, 32'h0);
      checkOutput("asyncRstErr", {30'h0, err}, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      charReady = 1'b1;
      rdBefore = rdCount;
      repeat (5) tick();
      checkOutput("noReadAfterRst", 32'(rdCount - rdBefore), 32'd0);
      checkOutput("noCharAfterRst", {31'h0, charValid}, 32'h0);

      // Normal walk after reset
      doneBefore = doneCount;
      expQ.push_back(8'h48);
      expQ.push_back(8'h69);
      applyStimulus(STR_A, 16'h2000);
      waitIdle(100);
      checkOutput("postRstDone", 32'(doneCount - doneBefore), 32'd1);
      checkOutput("postRstQueueEmpty", 32'(expQ.size()), 32'd0);
      checkOutput("postRstErr", {30'h0, err}, 32'h0);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
